// File: rtl/btn_conditioner.sv
// Conditions three raw push buttons into stopwatch controls: run-level toggle, store pulse, load pulse.
// Optional macro BTN_RUN_LOCKOUT_EN suppresses store/load events while running.
module btn_conditioner #(
  parameter int DB_CYCLES = 1_000_000,
  parameter int CNT_W     = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_start,
  input  logic btn_store,
  input  logic btn_load,
  output logic en,
  output logic store,
  output logic load
);

  localparam logic [CNT_W-1:0] DbLast = CNT_W'(DB_CYCLES - 1);

  // Bit 0 = start, bit 1 = store, bit 2 = load throughout.
  logic [2:0]            rawBtn;
  logic [2:0]            syncMeta_q;
  logic [2:0]            syncOut_q;
  logic [2:0]            stable_q;
  logic [2:0]            stable_d;
  logic [2:0]            stableDly_q;
  logic [2:0][CNT_W-1:0] cnt_q;
  logic [2:0][CNT_W-1:0] cnt_d;
  logic [2:0]            press;
  logic                  sideAllowed;
  logic                  en_q;
  logic                  en_d;
  logic                  store_q;
  logic                  store_d;
  logic                  load_q;
  logic                  load_d;

  assign rawBtn = {btn_load, btn_store, btn_start};

  // The counter only runs while the synchronized level disagrees with the accepted level.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    for (int i = 0; i < 3; i++) begin
      if (syncOut_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DbLast) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign press = stable_q & ~stableDly_q;

`ifdef BTN_RUN_LOCKOUT_EN
  assign sideAllowed = ~en_q;
`else
  assign sideAllowed = 1'b1;
`endif

  // Start wins over store, store wins over load; losers are dropped, never queued.
  always_comb begin
    en_d    = en_q ^ press[0];
    store_d = sideAllowed & press[1] & ~press[0];
    load_d  = sideAllowed & press[2] & ~press[1] & ~press[0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      syncMeta_q  <= '0;
      syncOut_q   <= '0;
      stable_q    <= '0;
      stableDly_q <= '0;
      cnt_q       <= '0;
      en_q        <= 1'b0;
      store_q     <= 1'b0;
      load_q      <= 1'b0;
    end else begin
      syncMeta_q  <= rawBtn;
      syncOut_q   <= syncMeta_q;
      stable_q    <= stable_d;
      stableDly_q <= stable_q;
      cnt_q       <= cnt_d;
      en_q        <= en_d;
      store_q     <= store_d;
      load_q      <= load_d;
    end
  end

  assign en    = en_q;
  assign store = store_q;
  assign load  = load_q;

endmodule
